// File: rtl/sha2_pkg.sv
// ---------------------------------------------------------------------------
// sha2_pkg
// Shared SHA-256 constants for the cracker's hash cores:
//   ROUNDS   number of compression rounds per block (64)
//   K_TABLE  the 64 round constants K[0..63]
//   H_IV     initial hash value H0..H7 packed with H0 in the MSBs
//   kseq_state_t  sequencer state encoding {IDLE, PRELOAD, RUN, DONE}
// ---------------------------------------------------------------------------
package sha2_pkg;

   localparam int ROUNDS = 64;

   localparam logic [31:0] K_TABLE [0:ROUNDS-1] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [255:0] H_IV = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRELOAD = 2'd1,
      RUN     = 2'd2,
      DONE    = 2'd3
   } kseq_state_t;

endpackage

// File: rtl/sha256_k_rom.sv
// ---------------------------------------------------------------------------
// sha256_k_rom
// Combinational lookup of the SHA-256 round constant.
//   idx  in   6   round index t
//   k    out  32  K[t]
// ---------------------------------------------------------------------------
module sha256_k_rom
   import sha2_pkg::*;
(
   input  logic [5:0]  idx,
   output logic [31:0] k
);

   // Pure table read; the caller registers the result.
   assign k = K_TABLE[idx];

endmodule

// File: rtl/sha256_kseq.sv
// ---------------------------------------------------------------------------
// sha256_kseq
// Round sequencer and K-constant source shared by several iterative hash
// cores. A pass walks rounds 0..63 with NUM_CH channels interleaved per
// round (channel fastest), presenting a registered K[t] plus indices.
//   clk         in   1     clock, posedge
//   rst         in   1     asynchronous active-low reset
//   start       in   1     request a pass (IDLE only)
//   stall       in   1     freeze the current beat
//   abort       in   1     synchronous cancel, back to IDLE
//   busy        out  1     pass in progress (PRELOAD/RUN/DONE)
//   k_valid     out  1     k_out/round_idx/ch_idx valid
//   k_out       out  32    K[round_idx]
//   round_idx   out  6     round t
//   ch_idx      out  CH_W  channel
//   last_round  out  1     final beat of the pass is on the outputs
//   done        out  1     one-cycle pulse after the final beat
// Optional macro SHA256_KSEQ_IV_OUT_EN adds a PRELOAD phase of NUM_CH
// beats presenting the initial hash value:
//   iv_valid    out  1     iv_out valid, ch_idx names the channel
//   iv_out      out  256   H0..H7, H0 in the MSBs
// ---------------------------------------------------------------------------
module sha256_kseq
   import sha2_pkg::*;
#(
   parameter  int NUM_CH = 4,
   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            stall,
   input  logic            abort,
   output logic            busy,
   output logic            k_valid,
   output logic [31:0]     k_out,
   output logic [5:0]      round_idx,
   output logic [CH_W-1:0] ch_idx,
   output logic            last_round,
   output logic            done
`ifdef SHA256_KSEQ_IV_OUT_EN
   ,
   output logic            iv_valid,
   output logic [255:0]    iv_out
`endif
);

   localparam logic [CH_W-1:0] CH_LAST    = CH_W'(NUM_CH - 1);
   localparam logic [5:0]      ROUND_LAST = 6'(ROUNDS - 1);

   kseq_state_t     state, nxt_state;
   logic [5:0]      nxt_round;
   logic [CH_W-1:0] nxt_ch;
   logic            nxt_kv;
   logic [31:0]     rom_k;
`ifdef SHA256_KSEQ_IV_OUT_EN
   logic            nxt_iv;
`endif

   // The ROM is addressed with the index the outputs will hold after the
   // edge, so k_out is a plain register with no path from start.
   sha256_k_rom u_rom (
      .idx (nxt_round),
      .k   (rom_k)
   );

   // Status outputs decode directly from registered state.
   assign busy       = (state != IDLE);
   assign done       = (state == DONE);
   assign last_round = k_valid && (round_idx == ROUND_LAST) && (ch_idx == CH_LAST);
`ifdef SHA256_KSEQ_IV_OUT_EN
   assign iv_out     = iv_valid ? H_IV : '0;
`endif

   // Next-state and next-beat logic. Abort overrides everything and clears
   // the counters; stall only holds beats in PRELOAD and RUN, so it has no
   // effect on IDLE or DONE.
   always_comb begin
      nxt_state = state;
      nxt_round = round_idx;
      nxt_ch    = ch_idx;
      nxt_kv    = k_valid;
`ifdef SHA256_KSEQ_IV_OUT_EN
      nxt_iv    = iv_valid;
`endif
      if (abort) begin
         nxt_state = IDLE;
         nxt_round = '0;
         nxt_ch    = '0;
         nxt_kv    = 1'b0;
`ifdef SHA256_KSEQ_IV_OUT_EN
         nxt_iv    = 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  nxt_round = '0;
                  nxt_ch    = '0;
`ifdef SHA256_KSEQ_IV_OUT_EN
                  nxt_state = PRELOAD;
                  nxt_iv    = 1'b1;
`else
                  nxt_state = RUN;
                  nxt_kv    = 1'b1;
`endif
               end
            end
            PRELOAD: begin
`ifdef SHA256_KSEQ_IV_OUT_EN
               if (!stall) begin
                  if (ch_idx == CH_LAST) begin
                     nxt_state = RUN;
                     nxt_iv    = 1'b0;
                     nxt_kv    = 1'b1;
                     nxt_ch    = '0;
                     nxt_round = '0;
                  end else begin
                     nxt_ch = ch_idx + CH_W'(1);
                  end
               end
`else
               nxt_state = IDLE;
`endif
            end
            RUN: begin
               if (!stall) begin
                  if (ch_idx == CH_LAST) begin
                     nxt_ch = '0;
                     if (round_idx == ROUND_LAST) begin
                        nxt_state = DONE;
                        nxt_kv    = 1'b0;
                        nxt_round = '0;
                     end else begin
                        nxt_round = round_idx + 6'd1;
                     end
                  end else begin
                     nxt_ch = ch_idx + CH_W'(1);
                  end
               end
            end
            DONE: begin
               nxt_state = IDLE;
            end
            default: begin
               nxt_state = IDLE;
            end
         endcase
      end
   end

   // State and output registers. k_out is zeroed whenever no beat is
   // valid so idle outputs look the same as after reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         round_idx <= '0;
         ch_idx    <= '0;
         k_valid   <= 1'b0;
         k_out     <= '0;
`ifdef SHA256_KSEQ_IV_OUT_EN
         iv_valid  <= 1'b0;
`endif
      end else begin
         state     <= nxt_state;
         round_idx <= nxt_round;
         ch_idx    <= nxt_ch;
         k_valid   <= nxt_kv;
         k_out     <= nxt_kv ? rom_k : '0;
`ifdef SHA256_KSEQ_IV_OUT_EN
         iv_valid  <= nxt_iv;
`endif
      end
   end

endmodule

// File: tb/tb_sha256_kseq.sv
// ---------------------------------------------------------------------------
// tb_sha256_kseq
// Bench for sha256_kseq with a one-channel and a four-channel instance
// (plus a two-channel instance when SHA256_KSEQ_IV_OUT_EN is defined).
// Expected beats come from the K table and index arithmetic:
// beat b -> round b/NUM_CH, channel b%NUM_CH, K[b/NUM_CH].
// ---------------------------------------------------------------------------
module tb_sha256_kseq;

`ifdef SHA256_KSEQ_IV_OUT_EN
   localparam int PRE_EN = 1;
`else
   localparam int PRE_EN = 0;
`endif

   localparam logic [31:0] K_TB [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   logic clk = 1'b0;
   logic rst;

   logic        s1, st1, ab1, busy1, kv1, lr1, d1;
   logic [31:0] k1;
   logic [5:0]  r1;
   logic [0:0]  c1;

   logic        s4, st4, ab4, busy4, kv4, lr4, d4;
   logic [31:0] k4;
   logic [5:0]  r4;
   logic [1:0]  c4;

   int errors = 0;
   int checks = 0;

`ifdef SHA256_KSEQ_IV_OUT_EN
   localparam logic [255:0] H_TB = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };
   logic         iv1, iv4;
   logic [255:0] ivo1, ivo4;
   logic         s2, st2, ab2, busy2, kv2, lr2, d2, iv2;
   logic [31:0]  k2;
   logic [5:0]   r2;
   logic [0:0]   c2;
   logic [255:0] ivo2;
`endif

   sha256_kseq #(.NUM_CH(1)) u1 (
      .clk(clk), .rst(rst), .start(s1), .stall(st1), .abort(ab1),
      .busy(busy1), .k_valid(kv1), .k_out(k1), .round_idx(r1), .ch_idx(c1),
      .last_round(lr1), .done(d1)
`ifdef SHA256_KSEQ_IV_OUT_EN
      , .iv_valid(iv1), .iv_out(ivo1)
`endif
   );

   sha256_kseq #(.NUM_CH(4)) u4 (
      .clk(clk), .rst(rst), .start(s4), .stall(st4), .abort(ab4),
      .busy(busy4), .k_valid(kv4), .k_out(k4), .round_idx(r4), .ch_idx(c4),
      .last_round(lr4), .done(d4)
`ifdef SHA256_KSEQ_IV_OUT_EN
      , .iv_valid(iv4), .iv_out(ivo4)
`endif
   );

`ifdef SHA256_KSEQ_IV_OUT_EN
   sha256_kseq #(.NUM_CH(2)) u2 (
      .clk(clk), .rst(rst), .start(s2), .stall(st2), .abort(ab2),
      .busy(busy2), .k_valid(kv2), .k_out(k2), .round_idx(r2), .ch_idx(c2),
      .last_round(lr2), .done(d2), .iv_valid(iv2), .iv_out(ivo2)
   );
`endif

   always #5 clk = ~clk;

   // Advance one clock and land 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      $display("[TB] reset state");
      #2;
      checks++;
      if ({busy1, kv1, k1, r1, c1, lr1, d1} !== '0) begin
         errors++;
         $display("FAIL reset_u1: got %h, expected 0", {busy1, kv1, k1, r1, c1, lr1, d1});
      end
      checks++;
      if ({busy4, kv4, k4, r4, c4, lr4, d4} !== '0) begin
         errors++;
         $display("FAIL reset_u4: got %h, expected 0", {busy4, kv4, k4, r4, c4, lr4, d4});
      end
`ifdef SHA256_KSEQ_IV_OUT_EN
      checks++;
      if ({iv1, ivo1, iv4, ivo4} !== '0) begin
         errors++;
         $display("FAIL reset_iv: iv1=%b iv4=%b, expected 0", iv1, iv4);
      end
`endif
      tick();
      #2 rst = 1'b1;
      tick();
      checks++;
      if (busy1 !== 1'b0 || kv1 !== 1'b0 || busy4 !== 1'b0 || kv4 !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_idle: busy1=%b kv1=%b busy4=%b kv4=%b, expected all 0",
                  busy1, kv1, busy4, kv4);
      end
   endtask

   task automatic test_single_channel();
      $display("[TB] NUM_CH=1 full pass");
      s1 = 1'b1;
      tick();
      s1 = 1'b0;
      for (int i = 0; i < PRE_EN; i++) tick();
      for (int b = 0; b < 64; b++) begin
         checks++;
         if (kv1 !== 1'b1 || k1 !== K_TB[b] || r1 !== 6'(b) || c1 !== 1'b0) begin
            errors++;
            $display("FAIL single_beat%0d: kv=%b k=%h t=%0d ch=%0d, expected kv=1 k=%h t=%0d ch=0",
                     b, kv1, k1, r1, c1, K_TB[b], b);
         end
         checks++;
         if (lr1 !== 1'(b == 63) || d1 !== 1'b0 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL single_flags%0d: last=%b done=%b busy=%b, expected last=%b done=0 busy=1",
                     b, lr1, d1, busy1, b == 63);
         end
         tick();
      end
      checks++;
      if (d1 !== 1'b1 || busy1 !== 1'b1 || kv1 !== 1'b0) begin
         errors++;
         $display("FAIL single_done: done=%b busy=%b kv=%b, expected 1 1 0", d1, busy1, kv1);
      end
      tick();
      checks++;
      if (d1 !== 1'b0 || busy1 !== 1'b0) begin
         errors++;
         $display("FAIL single_idle: done=%b busy=%b, expected 0 0", d1, busy1);
      end
   endtask

   task automatic test_multi_channel();
      $display("[TB] NUM_CH=4 full pass");
      s4 = 1'b1;
      tick();
      s4 = 1'b0;
      for (int i = 0; i < PRE_EN * 4; i++) tick();
      for (int b = 0; b < 256; b++) begin
         checks++;
         if (kv4 !== 1'b1 || k4 !== K_TB[b / 4] || r4 !== 6'(b / 4) || c4 !== 2'(b % 4)
             || lr4 !== 1'(b == 255) || d4 !== 1'b0) begin
            errors++;
            $display("FAIL multi_beat%0d: kv=%b k=%h t=%0d ch=%0d last=%b done=%b, expected kv=1 k=%h t=%0d ch=%0d last=%b done=0",
                     b, kv4, k4, r4, c4, lr4, d4, K_TB[b / 4], b / 4, b % 4, b == 255);
         end
         tick();
      end
      checks++;
      if (d4 !== 1'b1 || kv4 !== 1'b0) begin
         errors++;
         $display("FAIL multi_done: done=%b kv=%b, expected 1 0", d4, kv4);
      end
      tick();
      checks++;
      if (busy4 !== 1'b0) begin
         errors++;
         $display("FAIL multi_idle: busy=%b, expected 0", busy4);
      end
   endtask

   task automatic test_stall();
      $display("[TB] NUM_CH=1 stall at t=10");
      // stall alongside start in IDLE has no effect on acceptance
      s1  = 1'b1;
      st1 = 1'b1;
      tick();
      s1  = 1'b0;
      st1 = 1'b0;
      checks++;
      if (busy1 !== 1'b1) begin
         errors++;
         $display("FAIL stall_idle_ignored: busy=%b, expected 1", busy1);
      end
      for (int i = 0; i < PRE_EN; i++) tick();
      for (int t = 0; t < 64; t++) begin
         checks++;
         if (kv1 !== 1'b1 || k1 !== K_TB[t] || r1 !== 6'(t)) begin
            errors++;
            $display("FAIL stall_beat%0d: kv=%b k=%h t=%0d, expected kv=1 k=%h t=%0d",
                     t, kv1, k1, r1, K_TB[t], t);
         end
         if (t == 10) begin
            st1 = 1'b1;
            for (int h = 0; h < 3; h++) begin
               tick();
               checks++;
               if (kv1 !== 1'b1 || k1 !== 32'h243185be || r1 !== 6'd10) begin
                  errors++;
                  $display("FAIL stall_hold%0d: kv=%b k=%h t=%0d, expected kv=1 k=243185be t=10",
                           h, kv1, k1, r1);
               end
            end
            st1 = 1'b0;
         end
         tick();
      end
      checks++;
      if (d1 !== 1'b1) begin
         errors++;
         $display("FAIL stall_done_late: done=%b, expected 1", d1);
      end
      tick();
   endtask

   task automatic test_random_stall();
      int b;
      int cycles;
      $display("[TB] NUM_CH=4 random stall");
      s4 = 1'b1;
      tick();
      s4 = 1'b0;
      for (int i = 0; i < PRE_EN * 4; i++) tick();
      b = 0;
      cycles = 0;
      while (b < 256 && cycles < 2000) begin
         checks++;
         if (kv4 !== 1'b1 || k4 !== K_TB[b / 4] || r4 !== 6'(b / 4) || c4 !== 2'(b % 4)) begin
            errors++;
            $display("FAIL rstall_beat%0d: kv=%b k=%h t=%0d ch=%0d, expected kv=1 k=%h t=%0d ch=%0d",
                     b, kv4, k4, r4, c4, K_TB[b / 4], b / 4, b % 4);
         end
         st4 = ($urandom_range(0, 2) == 0);
         if (!st4) b++;
         tick();
         cycles++;
      end
      checks++;
      if (b != 256) begin
         errors++;
         $display("FAIL rstall_budget: beats=%0d, expected 256", b);
      end
      // stall held through the DONE cycle must not extend it
      st4 = 1'b1;
      checks++;
      if (d4 !== 1'b1 || kv4 !== 1'b0) begin
         errors++;
         $display("FAIL rstall_done: done=%b kv=%b, expected 1 0", d4, kv4);
      end
      tick();
      st4 = 1'b0;
      checks++;
      if (busy4 !== 1'b0 || d4 !== 1'b0) begin
         errors++;
         $display("FAIL rstall_done_ignores_stall: busy=%b done=%b, expected 0 0", busy4, d4);
      end
   endtask

   task automatic test_abort();
      int a;
      logic seen;
      $display("[TB] abort");
      s1 = 1'b1;
      tick();
      s1 = 1'b0;
      for (int i = 0; i < PRE_EN; i++) tick();
      for (int t = 0; t < 20; t++) tick();
      checks++;
      if (r1 !== 6'd20 || k1 !== K_TB[20]) begin
         errors++;
         $display("FAIL abort_pre: t=%0d k=%h, expected t=20 k=%h", r1, k1, K_TB[20]);
      end
      ab1 = 1'b1;
      tick();
      ab1 = 1'b0;
      checks++;
      if (kv1 !== 1'b0 || busy1 !== 1'b0 || d1 !== 1'b0) begin
         errors++;
         $display("FAIL abort_t20: kv=%b busy=%b done=%b, expected 0 0 0", kv1, busy1, d1);
      end
      seen = 1'b0;
      for (int i = 0; i < 70; i++) begin
         if (d1 === 1'b1 || busy1 === 1'b1) seen = 1'b1;
         tick();
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL abort_no_done: activity=%b, expected 0", seen);
      end
      // abort beats start in the same IDLE cycle
      s1  = 1'b1;
      ab1 = 1'b1;
      tick();
      s1  = 1'b0;
      ab1 = 1'b0;
      checks++;
      if (busy1 !== 1'b0 || kv1 !== 1'b0) begin
         errors++;
         $display("FAIL abort_vs_start: busy=%b kv=%b, expected 0 0", busy1, kv1);
      end
      s1 = 1'b1;
      tick();
      s1 = 1'b0;
      for (int i = 0; i < PRE_EN; i++) tick();
      checks++;
      if (kv1 !== 1'b1 || r1 !== 6'd0 || k1 !== K_TB[0]) begin
         errors++;
         $display("FAIL abort_restart: kv=%b t=%0d k=%h, expected kv=1 t=0 k=%h", kv1, r1, k1, K_TB[0]);
      end
      // abort beats stall
      for (int i = 0; i < 5; i++) tick();
      st1 = 1'b1;
      ab1 = 1'b1;
      tick();
      st1 = 1'b0;
      ab1 = 1'b0;
      checks++;
      if (busy1 !== 1'b0 || kv1 !== 1'b0) begin
         errors++;
         $display("FAIL abort_vs_stall: busy=%b kv=%b, expected 0 0", busy1, kv1);
      end
      // random abort point on the four-channel instance
      a = $urandom_range(1, 255);
      s4 = 1'b1;
      tick();
      s4 = 1'b0;
      for (int i = 0; i < PRE_EN * 4; i++) tick();
      for (int b = 0; b < a; b++) tick();
      checks++;
      if (r4 !== 6'(a / 4) || c4 !== 2'(a % 4) || k4 !== K_TB[a / 4]) begin
         errors++;
         $display("FAIL abort_rand_pre%0d: t=%0d ch=%0d k=%h, expected t=%0d ch=%0d k=%h",
                  a, r4, c4, k4, a / 4, a % 4, K_TB[a / 4]);
      end
      ab4 = 1'b1;
      tick();
      ab4 = 1'b0;
      checks++;
      if (kv4 !== 1'b0 || busy4 !== 1'b0 || r4 !== 6'd0 || c4 !== 2'd0 || d4 !== 1'b0) begin
         errors++;
         $display("FAIL abort_rand%0d: kv=%b busy=%b t=%0d ch=%0d done=%b, expected all 0",
                  a, kv4, busy4, r4, c4, d4);
      end
   endtask

   task automatic test_reset_midrun();
      $display("[TB] reset mid-run");
      s1 = 1'b1;
      tick();
      s1 = 1'b0;
      for (int i = 0; i < PRE_EN; i++) tick();
      for (int t = 0; t < 30; t++) tick();
      checks++;
      if (r1 !== 6'd30 || k1 !== K_TB[30]) begin
         errors++;
         $display("FAIL midrun_pre: t=%0d k=%h, expected t=30 k=%h", r1, k1, K_TB[30]);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({busy1, kv1, k1, r1, c1, lr1, d1} !== '0) begin
         errors++;
         $display("FAIL midrun_async_clear: got %h, expected 0", {busy1, kv1, k1, r1, c1, lr1, d1});
      end
      tick();
      #2 rst = 1'b1;
      tick();
      tick();
      checks++;
      if (busy1 !== 1'b0 || kv1 !== 1'b0) begin
         errors++;
         $display("FAIL midrun_no_resume: busy=%b kv=%b, expected 0 0", busy1, kv1);
      end
      s1 = 1'b1;
      tick();
      s1 = 1'b0;
      for (int i = 0; i < PRE_EN; i++) tick();
      for (int b = 0; b < 64; b++) begin
         checks++;
         if (kv1 !== 1'b1 || k1 !== K_TB[b] || r1 !== 6'(b)) begin
            errors++;
            $display("FAIL midrun_pass%0d: kv=%b k=%h t=%0d, expected kv=1 k=%h t=%0d",
                     b, kv1, k1, r1, K_TB[b], b);
         end
         tick();
      end
      checks++;
      if (d1 !== 1'b1) begin
         errors++;
         $display("FAIL midrun_done: done=%b, expected 1", d1);
      end
      tick();
   endtask

`ifdef SHA256_KSEQ_IV_OUT_EN
   task automatic test_preload();
      $display("[TB] NUM_CH=2 preload");
      s2 = 1'b1;
      tick();
      s2 = 1'b0;
      for (int p = 0; p < 2; p++) begin
         checks++;
         if (iv2 !== 1'b1 || ivo2 !== H_TB || c2 !== 1'(p) || kv2 !== 1'b0) begin
            errors++;
            $display("FAIL preload_beat%0d: iv=%b ch=%0d kv=%b iv_out=%h, expected iv=1 ch=%0d kv=0 iv_out=%h",
                     p, iv2, c2, kv2, ivo2, p, H_TB);
         end
         tick();
      end
      for (int b = 0; b < 128; b++) begin
         checks++;
         if (kv2 !== 1'b1 || iv2 !== 1'b0 || k2 !== K_TB[b / 2] || r2 !== 6'(b / 2) || c2 !== 1'(b % 2)) begin
            errors++;
            $display("FAIL preload_run%0d: kv=%b iv=%b k=%h t=%0d ch=%0d, expected kv=1 iv=0 k=%h t=%0d ch=%0d",
                     b, kv2, iv2, k2, r2, c2, K_TB[b / 2], b / 2, b % 2);
         end
         tick();
      end
      checks++;
      if (d2 !== 1'b1 || busy2 !== 1'b1) begin
         errors++;
         $display("FAIL preload_done: done=%b busy=%b, expected 1 1", d2, busy2);
      end
      tick();
   endtask
`endif

   initial begin
      rst = 1'b0;
      s1 = 1'b0; st1 = 1'b0; ab1 = 1'b0;
      s4 = 1'b0; st4 = 1'b0; ab4 = 1'b0;
`ifdef SHA256_KSEQ_IV_OUT_EN
      s2 = 1'b0; st2 = 1'b0; ab2 = 1'b0;
`endif
      test_reset();
      test_single_channel();
      test_multi_channel();
      test_stall();
      test_random_stall();
      test_abort();
      test_reset_midrun();
`ifdef SHA256_KSEQ_IV_OUT_EN
      test_preload();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
